// File: rtl/pp_arbiter.sv
// ---------------------------------------------------------------------------
// pp_arbiter: round-robin share of one rounding/post-processing stage between
// FPU execution units, with a source-ID FIFO to tag results.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pp_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*43-1:0] req_op,
  output logic                pp_valid,
  input  logic                pp_ready,
  output logic [42:0]         pp_op,
  output logic                pp_flush,
  input  logic                pp_res_valid,
  output logic                pp_res_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic                busy
);

  localparam int OP_W  = 43;
  localparam int RR_W  = $clog2(N_REQ);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              stage_valid_q, stage_valid_d;
  logic [OP_W-1:0]   stage_op_q, stage_op_d;
  logic [ID_W-1:0]   stage_id_q, stage_id_d;
  logic [RR_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [ID_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              fire, load_en, found, push, pop;
  logic [RR_W-1:0]   winner;
  logic [RR_W:0]     scan;
  logic [OP_W-1:0]   win_op;

  assign pp_valid     = stage_valid_q && (count_q < CNT_W'(FIFO_DEPTH));
  assign fire         = pp_valid && pp_ready;
  assign load_en      = !stage_valid_q || fire;
  assign pp_op        = stage_op_q;
  assign pp_flush     = flush;
  assign rsp_valid    = pp_res_valid && (count_q != '0);
  assign pp_res_ready = rsp_ready;
  assign rsp_id       = fifo_q[rd_ptr_q];
  assign busy         = stage_valid_q || (count_q != '0);
  assign push         = fire;
  assign pop          = rsp_valid && rsp_ready;

  // Rotating priority scan starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr_q} + (RR_W+1)'(k);
      if (scan >= (RR_W+1)'(N_REQ)) begin
        scan = scan - (RR_W+1)'(N_REQ);
      end
      if (!found && req_valid[scan[RR_W-1:0]]) begin
        found  = 1'b1;
        winner = scan[RR_W-1:0];
      end
    end
  end

  always_comb begin
    win_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == RR_W'(i)) begin
        win_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  // Grants are withheld during reset and flush so no handshake is lost.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = load_en && found && (winner == RR_W'(i)) && req_valid[i]
                     && reset && !flush;
    end
  end

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_op_d    = stage_op_q;
    stage_id_d    = stage_id_q;
    ptr_d         = ptr_q;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (load_en) begin
      if (found) begin
        stage_valid_d = 1'b1;
        stage_op_d    = win_op;
        stage_id_d    = ID_W'(winner);
        ptr_d         = (winner == RR_W'(N_REQ-1)) ? '0 : winner + RR_W'(1);
      end else begin
        stage_valid_d = 1'b0;
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = stage_id_q;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      stage_valid_d = 1'b0;
      stage_op_d    = '0;
      stage_id_d    = '0;
      ptr_d         = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= 1'b0;
      stage_op_q    <= '0;
      stage_id_q    <= '0;
      ptr_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_op_q    <= stage_op_d;
      stage_id_q    <= stage_id_d;
      ptr_q         <= ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pp_arbiter: directed self-checking bench for pp_arbiter (N_REQ=4,
// ID_W=2, FIFO_DEPTH=2).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pp_arbiter;

  logic         clk;
  logic         reset;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [171:0] req_op;
  logic         pp_valid;
  logic         pp_ready;
  logic [42:0]  pp_op;
  logic         pp_flush;
  logic         pp_res_valid;
  logic         pp_res_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic         busy;

  logic [42:0]  opv [4];
  int           vectors;
  int           miscompares;
  int           fires;

  always_comb req_op = {opv[3], opv[2], opv[1], opv[0]};

  pp_arbiter #(.N_REQ(4), .ID_W(2), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .pp_valid     (pp_valid),
    .pp_ready     (pp_ready),
    .pp_op        (pp_op),
    .pp_flush     (pp_flush),
    .pp_res_valid (pp_res_valid),
    .pp_res_ready (pp_res_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    fires        = 0;
    reset        = 1'b0;
    flush        = 1'b0;
    req_valid    = '0;
    pp_ready     = 1'b0;
    pp_res_valid = 1'b0;
    rsp_ready    = 1'b0;
    // rm, man, exp, sgn, round, sticky, skip_round, IV, DZ
    opv[0] = {3'd0, 24'h800000, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    opv[1] = {3'd1, 24'hC00001, 10'd127, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    opv[2] = {3'd2, 24'hA5A5A5, 10'd300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    opv[3] = {3'd4, 24'hFFFFFF, 10'd1023, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (3) tick();
    settle();
    chk("rst_pp_valid", 64'(pp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pp_op", 64'(pp_op), 64'd0);
    reset = 1'b1;

    // Single requester
    req_valid = 4'b0001;
    pp_ready  = 1'b1;
    rsp_ready = 1'b1;
    settle();
    chk("single_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    settle();
    chk("single_pp_valid", 64'(pp_valid), 64'd1);
    chk("single_pp_op", 64'(pp_op), 64'(opv[0]));
    chk("single_no_grant", 64'(req_ready), 64'd0);
    tick();
    pp_res_valid = 1'b1;
    settle();
    chk("single_stage_empty", 64'(pp_valid), 64'd0);
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_id", 64'(rsp_id), 64'd0);
    chk("single_res_ready", 64'(pp_res_ready), 64'd1);
    tick();
    pp_res_valid = 1'b0;
    settle();
    chk("single_idle", 64'(busy), 64'd0);

    // Flush to bring the pointer back to 0
    flush = 1'b1;
    settle();
    chk("flush_fwd", 64'(pp_flush), 64'd1);
    tick();
    flush = 1'b0;

    // Fairness: grant order 0,1,2,3,0,1,2,3 and matching response IDs
    req_valid    = 4'b1111;
    pp_res_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      settle();
      chk("fair_grant", 64'(req_ready), (k < 8) ? 64'(1 << (k % 4)) : 64'd0);
      if (k >= 1 && k <= 8) chk("fair_pp_op", 64'(pp_op), 64'(opv[(k-1) % 4]));
      if (k >= 2) begin
        chk("fair_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("fair_rsp_id", 64'(rsp_id), 64'((k-2) % 4));
      end
      tick();
    end
    pp_res_valid = 1'b0;
    settle();
    chk("fair_idle", 64'(busy), 64'd0);

    // Backpressure: stage held stable, no grants
    pp_ready  = 1'b0;
    req_valid = 4'b1111;
    settle();
    chk("bp_first_grant", 64'(req_ready), 64'h1);
    tick();
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("bp_pp_op_stable", 64'(pp_op), 64'(opv[0]));
      chk("bp_no_grant", 64'(req_ready), 64'd0);
      chk("bp_pp_valid", 64'(pp_valid), 64'd1);
      tick();
    end
    pp_ready = 1'b1;
    settle();
    chk("bp_release_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    settle();
    chk("bp_next_loaded", 64'(pp_op), 64'(opv[1]));
    tick();
    pp_res_valid = 1'b1;
    settle();
    chk("bp_rsp_id0", 64'(rsp_id), 64'd0);
    tick();
    settle();
    chk("bp_rsp_id1", 64'(rsp_id), 64'd1);
    tick();
    pp_res_valid = 1'b0;
    settle();
    chk("bp_idle", 64'(busy), 64'd0);

    // FIFO full: exactly two issues with writeback stalled
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (pp_valid && pp_ready) fires++;
      tick();
    end
    settle();
    chk("full_fire_count", 64'(fires), 64'd2);
    chk("full_pp_valid", 64'(pp_valid), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_no_grant", 64'(req_ready), 64'd0);
    req_valid    = '0;
    rsp_ready    = 1'b1;
    pp_res_valid = 1'b1;
    settle();
    chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("full_rsp_id2", 64'(rsp_id), 64'd2);
    tick();
    settle();
    chk("full_rsp_id3", 64'(rsp_id), 64'd3);
    chk("full_resume", 64'(pp_valid), 64'd1);
    chk("full_resume_op", 64'(pp_op), 64'(opv[0]));
    tick();
    settle();
    chk("full_rsp_id0", 64'(rsp_id), 64'd0);
    tick();
    pp_res_valid = 1'b0;
    settle();
    chk("full_idle", 64'(busy), 64'd0);

    // Flush with two in flight and the stage loaded (pointer is 1 here)
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    repeat (3) tick();
    settle();
    chk("fl_pre_pp_valid", 64'(pp_valid), 64'd0);
    chk("fl_pre_busy", 64'(busy), 64'd1);
    req_valid = '0;
    flush     = 1'b1;
    settle();
    chk("fl_pp_flush", 64'(pp_flush), 64'd1);
    tick();
    flush        = 1'b0;
    pp_res_valid = 1'b1;
    rsp_ready    = 1'b1;
    settle();
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_pp_valid", 64'(pp_valid), 64'd0);
    chk("fl_dropped_rsp", 64'(rsp_valid), 64'd0);
    chk("fl_pp_flush_low", 64'(pp_flush), 64'd0);
    req_valid = 4'b1010;
    settle();
    chk("fl_grant_from_0", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    settle();
    chk("fl_new_op", 64'(pp_op), 64'(opv[1]));
    chk("fl_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    settle();
    chk("fl_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("fl_rsp_id", 64'(rsp_id), 64'd1);
    tick();
    pp_res_valid = 1'b0;
    settle();
    chk("fl_idle", 64'(busy), 64'd0);

    // Asynchronous reset while requesting
    req_valid    = 4'b1111;
    pp_ready     = 1'b1;
    rsp_ready    = 1'b1;
    pp_res_valid = 1'b1;
    tick();
    tick();
    settle();
    chk("ar_pre_rsp_valid", 64'(rsp_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_pp_valid", 64'(pp_valid), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'd0);
    chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    tick();
    reset     = 1'b1;
    req_valid = '0;
    settle();
    chk("ar_post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ar_post_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
